// File: rtl/sar_search_8bit.sv
// Purpose : successive-approximation search that recovers a hidden 8-bit target through an external comparator.
// Latency : probeCount*(SETTLE_CYCLES+1) edges from the accept edge to the edge that raises done.
// Backpress: none; start is sampled only in IDLE, and a start while busy (including DONE) is dropped.
//
// Ports:
//   clock, resetN           - single rising-edge clock, asynchronous active-low reset
//   start                   - request a search (IDLE only)
//   probeValue              - registered trial value driven to the comparator P operand
//   pLessThanQ/pEqualToQ/pGreaterThanQ - comparator flags for probeValue vs. target
//   busy                    - high in every state except IDLE
//   done                    - one-cycle completion pulse (high while in DONE)
//   result, errorFlag       - recovered value and flag-sanity error, held until next accepted start
//   probeCount              - number of flag samples taken in the last/current search (1..8)
module sar_search_8bit #(
    parameter int unsigned SETTLE_CYCLES = 0
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       start,
    output logic [7:0] probeValue,
    input  logic       pLessThanQ,
    input  logic       pEqualToQ,
    input  logic       pGreaterThanQ,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] probeCount,
    output logic       errorFlag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [2:0] bitIndex;
    logic [3:0] settleCnt;

    logic       flagsOneHot;
    logic [7:0] bitMask;
    logic [7:0] workingValue;
    logic [7:0] nextProbe;

    // Exactly one of the three comparator flags may be set; anything else is a faulty comparator.
    assign flagsOneHot = ( pLessThanQ && !pEqualToQ && !pGreaterThanQ) ||
                         (!pLessThanQ &&  pEqualToQ && !pGreaterThanQ) ||
                         (!pLessThanQ && !pEqualToQ &&  pGreaterThanQ);

    // Trial bit under test; cleared when the probe overshot the target, kept otherwise.
    assign bitMask      = 8'h01 << bitIndex;
    assign workingValue = pGreaterThanQ ? (probeValue & ~bitMask) : probeValue;
    // Next trial sets the next lower bit on top of the resolved upper bits.
    assign nextProbe    = workingValue | (bitMask >> 1);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            probeValue <= 8'h00;
            result     <= 8'h00;
            probeCount <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            errorFlag  <= 1'b0;
            bitIndex   <= 3'd7;
            settleCnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= PROBE;
                        busy       <= 1'b1;
                        bitIndex   <= 3'd7;
                        probeValue <= 8'h80;
                        probeCount <= 4'd0;
                        errorFlag  <= 1'b0;
                        settleCnt  <= SETTLE_LOAD;
                    end
                end

                PROBE, SETTLE: begin
                    if (settleCnt != 4'd0) begin
                        // Hold probeValue stable while the external comparator settles.
                        state     <= SETTLE;
                        settleCnt <= settleCnt - 4'd1;
                    end else begin
                        // At most 8 samples per search, so the 4-bit count never wraps.
                        probeCount <= probeCount + 4'd1;
                        if (!flagsOneHot) begin
                            errorFlag <= 1'b1;
                            result    <= probeValue;
                            state     <= DONE;
                            done      <= 1'b1;
                        end else if (pEqualToQ) begin
                            result <= probeValue;
                            state  <= DONE;
                            done   <= 1'b1;
                        end else if (bitIndex == 3'd0) begin
                            result <= workingValue;
                            state  <= DONE;
                            done   <= 1'b1;
                        end else begin
                            bitIndex   <= bitIndex - 3'd1;
                            probeValue <= nextProbe;
                            settleCnt  <= SETTLE_LOAD;
                            state      <= PROBE;
                        end
                    end
                end

                DONE: begin
                    // start seen here is dropped; it is only honoured from IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_8bit.sv
// Latency here is counted as the number of rising edges from the accept edge
// (inclusive) up to the edge after which done is observed high.
module tb_sar_search_8bit;

    logic       clock;
    logic       resetN;
    logic       start0, start2;
    logic [7:0] probe0, probe2, result0, result2;
    logic       lt0, eq0, gt0, lt2, eq2, gt2;
    logic       busy0, busy2, done0, done2, err0, err2;
    logic [3:0] count0, count2;

    logic [7:0] target;
    int         errAt;
    int         probeNum;
    int         holdBad;
    logic [7:0] probeLog[$];

    int passCnt;
    int totalCnt;

    logic forceErr;
    assign forceErr = (errAt != 0) && (probeNum == errAt);

    // Comparator model; on the selected sample it reports lt and gt together.
    assign lt0 = forceErr ? 1'b1 : (probe0 <  target);
    assign gt0 = forceErr ? 1'b1 : (probe0 >  target);
    assign eq0 = forceErr ? 1'b0 : (probe0 == target);
    assign lt2 = forceErr ? 1'b1 : (probe2 <  target);
    assign gt2 = forceErr ? 1'b1 : (probe2 >  target);
    assign eq2 = forceErr ? 1'b0 : (probe2 == target);

    sar_search_8bit #(.SETTLE_CYCLES(0)) dut0 (
        .clock(clock), .resetN(resetN), .start(start0), .probeValue(probe0),
        .pLessThanQ(lt0), .pEqualToQ(eq0), .pGreaterThanQ(gt0),
        .busy(busy0), .done(done0), .result(result0), .probeCount(count0), .errorFlag(err0)
    );

    sar_search_8bit #(.SETTLE_CYCLES(2)) dut2 (
        .clock(clock), .resetN(resetN), .start(start2), .probeValue(probe2),
        .pLessThanQ(lt2), .pEqualToQ(eq2), .pGreaterThanQ(gt2),
        .busy(busy2), .done(done2), .result(result2), .probeCount(count2), .errorFlag(err2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic runSearch(input bit slow, input logic [7:0] tgt, input int errAt_,
                             input bit noWait, output int lat);
        logic [7:0] pv;
        int held;
        target = tgt;
        errAt = errAt_;
        probeLog.delete();
        probeNum = 0;
        holdBad = 0;
        if (!noWait) @(negedge clock);
        if (slow) start2 = 1'b1; else start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        lat = 1;
        pv = slow ? probe2 : probe0;
        probeLog.push_back(pv);
        probeNum = 1;
        held = 1;
        while (lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
            if (slow ? done2 : done0) break;
            pv = slow ? probe2 : probe0;
            if (pv != probeLog[$]) begin
                if (slow && held != 3) holdBad++;
                probeLog.push_back(pv);
                probeNum++;
                held = 1;
            end else begin
                held++;
            end
        end
        if (lat >= 200) check("search_timeout", 32'(lat), 32'd0);
        errAt = 0;
    endtask

    task automatic checkProbes(input string name, input logic [7:0] exp[8], input int n);
        check({name, "_probe_count"}, 32'(probeLog.size()), 32'(n));
        for (int i = 0; i < n && i < probeLog.size(); i++)
            check($sformatf("%s_probe%0d", name, i), 32'(probeLog[i]), 32'(exp[i]));
    endtask

    typedef struct {
        bit         slow;
        logic [7:0] tgt;
        int         errAt;
        logic [7:0] expResult;
        logic [3:0] expCount;
        logic       expErr;
        int         expLat;
    } vec_t;

    vec_t vecs[9];
    logic [7:0] exp5A[8];
    logic [7:0] exp00[8];
    logic [7:0] expFF[8];

    initial begin
        int lat;
        passCnt = 0;
        totalCnt = 0;
        start0 = 1'b0;
        start2 = 1'b0;
        target = 8'h00;
        errAt = 0;
        probeNum = 0;
        holdBad = 0;

        vecs[0] = '{0, 8'h5A, 0, 8'h5A, 4'd7, 1'b0, 8};
        vecs[1] = '{0, 8'h00, 0, 8'h00, 4'd8, 1'b0, 9};
        vecs[2] = '{0, 8'h80, 0, 8'h80, 4'd1, 1'b0, 2};
        vecs[3] = '{0, 8'h33, 0, 8'h33, 4'd8, 1'b0, 9};
        vecs[4] = '{0, 8'h7F, 0, 8'h7F, 4'd8, 1'b0, 9};
        vecs[5] = '{0, 8'h01, 0, 8'h01, 4'd8, 1'b0, 9};
        vecs[6] = '{0, 8'hC3, 0, 8'hC3, 4'd8, 1'b0, 9};
        vecs[7] = '{0, 8'h5A, 3, 8'h60, 4'd3, 1'b1, 4};
        vecs[8] = '{1, 8'hFF, 0, 8'hFF, 4'd8, 1'b0, 25};

        exp5A = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h00};
        exp00 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        expFF = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

        // Reset state
        resetN = 1'b0;
        #12;
        check("rst_probe", 32'(probe0), 32'h0);
        check("rst_result", 32'(result0), 32'h0);
        check("rst_count", 32'(count0), 32'h0);
        check("rst_busy_done_err", {29'd0, busy0, done0, err0}, 32'h0);
        @(negedge clock);
        resetN = 1'b1;

        // Table-driven searches
        for (int i = 0; i < 9; i++) begin
            runSearch(vecs[i].slow, vecs[i].tgt, vecs[i].errAt, 1'b0, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
            check($sformatf("v%0d_result", i), 32'(vecs[i].slow ? result2 : result0), 32'(vecs[i].expResult));
            check($sformatf("v%0d_count", i), 32'(vecs[i].slow ? count2 : count0), 32'(vecs[i].expCount));
            check($sformatf("v%0d_err", i), 32'(vecs[i].slow ? err2 : err0), 32'(vecs[i].expErr));
            check($sformatf("v%0d_busy_in_done", i), 32'(vecs[i].slow ? busy2 : busy0), 32'd1);
            if (i == 0) checkProbes("t5A", exp5A, 7);
            if (i == 1) checkProbes("t00", exp00, 8);
            if (i == 8) begin
                checkProbes("tFF", expFF, 8);
                check("tFF_hold3", 32'(holdBad), 32'd0);
            end
            @(posedge clock);
            #1;
            check($sformatf("v%0d_done_pulse1", i), 32'(vecs[i].slow ? done2 : done0), 32'd0);
            check($sformatf("v%0d_idle_busy", i), 32'(vecs[i].slow ? busy2 : busy0), 32'd0);
            check($sformatf("v%0d_result_held", i), 32'(vecs[i].slow ? result2 : result0), 32'(vecs[i].expResult));
        end

        // start held high: ignored in DONE, accepted from IDLE next cycle
        target = 8'h80;
        @(negedge clock);
        start0 = 1'b1;
        @(posedge clock); #1;
        check("hold_accept_busy", 32'(busy0), 32'd1);
        @(posedge clock); #1;
        check("hold_done", 32'(done0), 32'd1);
        @(posedge clock); #1;
        check("hold_ignored_in_done", 32'(busy0), 32'd0);
        @(posedge clock); #1;
        check("hold_reaccept_busy", 32'(busy0), 32'd1);
        check("hold_reaccept_count", 32'(count0), 32'd0);
        check("hold_reaccept_probe", 32'(probe0), 32'h80);
        start0 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("hold_back_idle", 32'(busy0), 32'd0);

        // Asynchronous reset during the fourth probe
        target = 8'h33;
        @(negedge clock);
        start0 = 1'b1;
        @(posedge clock); #1;
        start0 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("mid_probe4", 32'(probe0), 32'h30);
        #2;
        resetN = 1'b0;
        #1;
        check("async_probe", 32'(probe0), 32'h0);
        check("async_result", 32'(result0), 32'h0);
        check("async_count", 32'(count0), 32'h0);
        check("async_busy_done_err", {29'd0, busy0, done0, err0}, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_no_done", {30'd0, done0, busy0}, 32'h0);
        @(negedge clock);
        resetN = 1'b1;
        runSearch(1'b0, 8'h33, 0, 1'b1, lat);
        check("post_rst_latency", 32'(lat), 32'd9);
        check("post_rst_result", 32'(result0), 32'h33);
        check("post_rst_err", 32'(err0), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/sar_search_8bit.md
SAR_SEARCH_8BIT -- requirements
Module: sar_search_8bit

Interface
REQ-001 Parameter SETTLE_CYCLES, default 0, is the number of extra clock cycles `probeValue` is held stable before the compare flags are sampled (range 0..15).
REQ-002 Port clock, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port resetN, input, 1, is the reset, which is asynchronous and active-low.
REQ-004 Port start, input, 1, requests a new search and is sampled only in IDLE.
REQ-005 Port probeValue, output, 8, is the registered trial value driven to the external 8-bit comparator P operand; Q is the hidden target.
REQ-006 Port pLessThanQ, input, 1, is the comparator flag probeValue < target.
REQ-007 Port pEqualToQ, input, 1, is the comparator flag probeValue == target.
REQ-008 Port pGreaterThanQ, input, 1, is the comparator flag probeValue > target.
REQ-009 Port busy, output, 1, is high in every state except IDLE.
REQ-010 Port done, output, 1, is a one-cycle pulse marking search completion.
REQ-011 Port result, output, 8, is the recovered target value, held from done until the next accepted start.
REQ-012 Port probeCount, output, 4, is the number of compares sampled in the last or current search (1..8).
REQ-013 Port errorFlag, output, 1, goes high when sampled flags were not exactly one-hot; it is held with result.

Function
REQ-014 The block SHALL implement states IDLE, PROBE, SETTLE and DONE, encoded in a registered state machine.
REQ-015 In IDLE, start=1 SHALL cause the next state to be PROBE; on the same edge it sets bitIndex=7, probeValue=8'h80, probeCount=0, errorFlag=0 and settle counter=SETTLE_CYCLES.
REQ-016 In IDLE, start=0 SHALL hold state and all outputs.
REQ-017 start while busy=1 SHALL be ignored, with no queuing and no restart.
REQ-018 In PROBE with settle counter >0, the state SHALL go to SETTLE and the counter SHALL decrement each cycle; flags SHALL be sampled on the edge where the counter is 0.
REQ-019 Each flag sample SHALL increment probeCount by 1.
REQ-020 If the flags are not one-hot (zero or more than one set), the block SHALL go to DONE with errorFlag=1 and result=probeValue.
REQ-021 On a pEqualToQ sample, the block SHALL go to DONE with result=probeValue (early termination).
REQ-022 On a pGreaterThanQ sample, the working value SHALL clear bit[bitIndex].
REQ-023 On a pLessThanQ sample, the working value SHALL keep bit[bitIndex].
REQ-024 After a non-equal sample with bitIndex>0, bitIndex SHALL decrement, probeValue SHALL become the working value with bit[bitIndex-1] set, the settle counter SHALL reload, and the state SHALL stay in PROBE.
REQ-025 After a non-equal sample with bitIndex=0, the block SHALL go to DONE with result=working value (bit0 cleared on gt, kept on lt).
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 probeValue SHALL hold its last value in IDLE and DONE.
REQ-028 Search latency (start-accept edge to done high) SHALL be probeCount*(SETTLE_CYCLES+1)+1 cycles.
REQ-029 The maximum probeCount SHALL be 8, and the 4-bit counter SHALL never wrap.
REQ-030 start=1 in the DONE cycle SHALL be ignored; start is accepted only from IDLE the following cycle.

Reset
REQ-031 resetN=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, probeValue=0, result=0, probeCount=0, busy=0, done=0, errorFlag=0, bitIndex=7 and settle counter=0.
REQ-032 Reset asserted mid-search SHALL abort the search with no done pulse, and the block SHALL accept start on the first edge after release.

Verification
REQ-033 Target 8'h5A, SETTLE_CYCLES=0 -> probes 80,40,60,50,58,5C,5A; then done=1, result=8'h5A, probeCount=7, errorFlag=0; done high 8 cycles after the accept edge.
REQ-034 Target 8'h00 -> probes 80,40,20,10,08,04,02,01, all gt; then result=8'h00, probeCount=8.
REQ-035 Target 8'h80 -> eq on the first probe; done 2 cycles after accept, result=8'h80, probeCount=1.
REQ-036 Target 8'hFF, SETTLE_CYCLES=2 -> probes 80,C0,E0,F0,F8,FC,FE,FF, each held 3 cycles; then result=8'hFF, probeCount=8, done 25 cycles after accept.
REQ-037 Flags lt=1 and gt=1 forced on the third sample -> done with errorFlag=1, probeCount=3, result=probeValue at that sample.
REQ-038 resetN pulsed low during the fourth probe -> all outputs 0 asynchronously with no done; then a new start for target 8'h33 completes with result=8'h33.
